// File: rtl/lsu_pkg.sv
// Shared load/store queue types for the LSU: queue geometry, entry layouts and
// the reason a load is parked in the forwarding unit's sleep table.
package lsu_pkg;

  localparam int LDQ_SIZE = 8;
  localparam int STQ_SIZE = 8;
  localparam int XLEN     = 32;
  localparam int MASK_W   = XLEN / 8;

  typedef struct packed {
    logic [XLEN-1:0]     address;
    logic [MASK_W-1:0]   byte_mask;
    logic [STQ_SIZE-1:0] store_mask;
  } load_queue_entry;

  typedef struct packed {
    logic              valid;
    logic              address_valid;
    logic [XLEN-1:0]   address;
    logic [MASK_W-1:0] byte_mask;
    logic              data_valid;
    logic [XLEN-1:0]   data;
  } store_queue_entry;

  typedef enum logic {
    SLEEP_DATA_PENDING = 1'b0,
    SLEEP_PARTIAL      = 1'b1
  } sleep_reason_e;

endpackage

// File: rtl/youngest_entry_select.sv
// Picks the youngest requesting slot of a circular queue, where age is the
// distance from the head (oldest) slot, wrapping around the end of the queue.
module youngest_entry_select #(
  parameter int QUEUE_SIZE = 8
) (
  input  logic [QUEUE_SIZE-1:0]         req,
  input  logic [$clog2(QUEUE_SIZE)-1:0] head,
  output logic                          found,
  output logic [$clog2(QUEUE_SIZE)-1:0] index
);

  localparam int IDX_W = $clog2(QUEUE_SIZE);

  always_comb begin
    int best_age;
    int age;
    found    = 1'b0;
    index    = '0;
    best_age = -1;
    age      = 0;
    for (int i = 0; i < QUEUE_SIZE; i++) begin
      age = (i >= int'(head)) ? (i - int'(head)) : (i + QUEUE_SIZE - int'(head));
      if (req[i] && (age > best_age)) begin
        found    = 1'b1;
        index    = IDX_W'(i);
        best_age = age;
      end
    end
  end

endmodule

// File: rtl/load_store_forward_unit.sv
// Store-to-load forwarding check for one load per cycle, plus a sleep table that
// parks blocked loads and wakes them (lowest LDQ index first) once unblocked.
module load_store_forward_unit #(
  parameter int LDQ_SIZE = lsu_pkg::LDQ_SIZE,
  parameter int STQ_SIZE = lsu_pkg::STQ_SIZE,
  parameter int XLEN     = lsu_pkg::XLEN
) (
  input  logic                          clk,
  input  logic                          reset,
  input  lsu_pkg::load_queue_entry      load_queue_entries  [LDQ_SIZE],
  input  lsu_pkg::store_queue_entry     store_queue_entries [STQ_SIZE],
  input  logic [$clog2(STQ_SIZE)-1:0]   stq_head,
  input  logic                          search_valid,
  input  logic [$clog2(LDQ_SIZE)-1:0]   search_ldq_index,
  input  logic                          flush,
  input  logic                          ldq_dealloc_valid,
  input  logic [$clog2(LDQ_SIZE)-1:0]   ldq_dealloc_index,
  output logic                          resp_valid,
  output logic [$clog2(LDQ_SIZE)-1:0]   resp_ldq_index,
  output logic                          resp_kill,
  output logic                          resp_forward,
  output logic                          resp_sleep,
  output logic [$clog2(STQ_SIZE)-1:0]   resp_stq_index,
  output logic [XLEN-1:0]               resp_data,
  output logic                          wakeup_valid,
  output logic [$clog2(LDQ_SIZE)-1:0]   wakeup_ldq_index,
  input  logic                          wakeup_ready
);

  import lsu_pkg::*;

  localparam int LW = $clog2(LDQ_SIZE);
  localparam int SW = $clog2(STQ_SIZE);
  localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  load_queue_entry     ld;
  store_queue_entry    hit_st;
  logic [STQ_SIZE-1:0] overlap;
  logic                hit;
  logic [SW-1:0]       hit_idx;
  logic                full_cover;
  logic                do_fwd;
  logic                do_sleep;

  logic [LDQ_SIZE-1:0] sleeping;
  logic [LDQ_SIZE-1:0] sleeping_nxt;
  logic [SW-1:0]       wait_idx     [LDQ_SIZE];
  logic [SW-1:0]       wait_idx_nxt [LDQ_SIZE];
  sleep_reason_e       reason       [LDQ_SIZE];
  sleep_reason_e       reason_nxt   [LDQ_SIZE];
  logic                wake_ack;
  logic                wake_found;
  logic [LW-1:0]       wake_idx;

  logic                vld_p1;
  logic [LW-1:0]       resp_ldq_index_p1;
  logic                resp_kill_p1;
  logic                resp_forward_p1;
  logic                resp_sleep_p1;
  logic [SW-1:0]       resp_stq_index_p1;
  logic [XLEN-1:0]     resp_data_p1;
  logic                wake_vld_p1;
  logic [LW-1:0]       wake_idx_p1;

  // Stage 0: overlap detection against every store for the searched load
  always_comb begin
    ld = load_queue_entries[search_ldq_index];
    for (int i = 0; i < STQ_SIZE; i++) begin
      overlap[i] = ld.store_mask[i]
                && store_queue_entries[i].valid
                && store_queue_entries[i].address_valid
                && ((store_queue_entries[i].address & WORD_MASK) == (ld.address & WORD_MASK))
                && (|(store_queue_entries[i].byte_mask & ld.byte_mask));
    end
  end

  youngest_entry_select #(
    .QUEUE_SIZE(STQ_SIZE)
  ) u_youngest_entry_select (
    .req   (overlap),
    .head  (stq_head),
    .found (hit),
    .index (hit_idx)
  );

  always_comb begin
    hit_st     = store_queue_entries[hit_idx];
    full_cover = ((hit_st.byte_mask & ld.byte_mask) == ld.byte_mask);
    do_fwd     = search_valid && hit && full_cover && hit_st.data_valid;
    do_sleep   = search_valid && hit && !do_fwd;
  end

  assign wake_ack = wake_vld_p1 && wakeup_ready;

  // Event priority on the sleep table: flush, then dealloc, then search, then wake ack
  always_comb begin
    sleeping_nxt = sleeping;
    wait_idx_nxt = wait_idx;
    reason_nxt   = reason;
    if (flush) begin
      sleeping_nxt = '0;
      for (int j = 0; j < LDQ_SIZE; j++) begin
        wait_idx_nxt[j] = '0;
        reason_nxt[j]   = SLEEP_DATA_PENDING;
      end
    end else begin
      if (wake_ack) sleeping_nxt[wake_idx_p1] = 1'b0;
      if (search_valid) begin
        sleeping_nxt[search_ldq_index] = do_sleep;
        if (do_sleep) begin
          wait_idx_nxt[search_ldq_index] = hit_idx;
          reason_nxt[search_ldq_index]   = full_cover ? SLEEP_DATA_PENDING : SLEEP_PARTIAL;
        end
      end
      if (ldq_dealloc_valid) sleeping_nxt[ldq_dealloc_index] = 1'b0;
    end
  end

  // Descending scan so the lowest eligible index is the one left standing
  always_comb begin
    wake_found = 1'b0;
    wake_idx   = '0;
    for (int j = LDQ_SIZE - 1; j >= 0; j--) begin
      if (sleeping_nxt[j]
          && (!store_queue_entries[wait_idx_nxt[j]].valid
              || ((reason_nxt[j] == SLEEP_DATA_PENDING)
                  && store_queue_entries[wait_idx_nxt[j]].data_valid))) begin
        wake_found = 1'b1;
        wake_idx   = LW'(j);
      end
    end
  end

  // Stage 1: registered response, sleep table and wakeup handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sleeping          <= '0;
      for (int j = 0; j < LDQ_SIZE; j++) begin
        wait_idx[j] <= '0;
        reason[j]   <= SLEEP_DATA_PENDING;
      end
      vld_p1            <= 1'b0;
      resp_ldq_index_p1 <= '0;
      resp_kill_p1      <= 1'b0;
      resp_forward_p1   <= 1'b0;
      resp_sleep_p1     <= 1'b0;
      resp_stq_index_p1 <= '0;
      resp_data_p1      <= '0;
      wake_vld_p1       <= 1'b0;
      wake_idx_p1       <= '0;
    end else begin
      sleeping <= sleeping_nxt;
      wait_idx <= wait_idx_nxt;
      reason   <= reason_nxt;
      if (flush) begin
        vld_p1            <= 1'b0;
        resp_ldq_index_p1 <= '0;
        resp_kill_p1      <= 1'b0;
        resp_forward_p1   <= 1'b0;
        resp_sleep_p1     <= 1'b0;
        resp_stq_index_p1 <= '0;
        resp_data_p1      <= '0;
      end else begin
        vld_p1            <= search_valid;
        resp_ldq_index_p1 <= search_valid ? search_ldq_index : '0;
        resp_kill_p1      <= search_valid && hit;
        resp_forward_p1   <= do_fwd;
        resp_sleep_p1     <= do_sleep;
        resp_stq_index_p1 <= do_fwd ? hit_idx : '0;
        resp_data_p1      <= do_fwd ? hit_st.data : '0;
      end
      if (flush) begin
        wake_vld_p1 <= 1'b0;
        wake_idx_p1 <= '0;
      end else if (!(wake_vld_p1 && !wakeup_ready)) begin
        wake_vld_p1 <= wake_found;
        wake_idx_p1 <= wake_found ? wake_idx : '0;
      end
    end
  end

  assign resp_valid       = vld_p1;
  assign resp_ldq_index   = resp_ldq_index_p1;
  assign resp_kill        = resp_kill_p1;
  assign resp_forward     = resp_forward_p1;
  assign resp_sleep       = resp_sleep_p1;
  assign resp_stq_index   = resp_stq_index_p1;
  assign resp_data        = resp_data_p1;
  assign wakeup_valid     = wake_vld_p1;
  assign wakeup_ldq_index = wake_idx_p1;

endmodule

// File: tb/tb_load_store_forward_unit.sv
// Bench for load_store_forward_unit: directed scenarios followed by random
// traffic, all checked cycle by cycle against a behavioural queue model.
module tb_load_store_forward_unit;
  import lsu_pkg::*;

  localparam int LQ = 8;
  localparam int SQ = 8;

  logic             clk = 1'b0;
  logic             reset;
  load_queue_entry  ldq [LQ];
  store_queue_entry stq [SQ];
  logic [2:0]       stq_head;
  logic             search_valid;
  logic [2:0]       search_ldq_index;
  logic             flush;
  logic             ldq_dealloc_valid;
  logic [2:0]       ldq_dealloc_index;
  logic             resp_valid;
  logic [2:0]       resp_ldq_index;
  logic             resp_kill;
  logic             resp_forward;
  logic             resp_sleep;
  logic [2:0]       resp_stq_index;
  logic [31:0]      resp_data;
  logic             wakeup_valid;
  logic [2:0]       wakeup_ldq_index;
  logic             wakeup_ready;

  load_store_forward_unit #(.LDQ_SIZE(LQ), .STQ_SIZE(SQ), .XLEN(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .load_queue_entries  (ldq),
    .store_queue_entries (stq),
    .stq_head            (stq_head),
    .search_valid        (search_valid),
    .search_ldq_index    (search_ldq_index),
    .flush               (flush),
    .ldq_dealloc_valid   (ldq_dealloc_valid),
    .ldq_dealloc_index   (ldq_dealloc_index),
    .resp_valid          (resp_valid),
    .resp_ldq_index      (resp_ldq_index),
    .resp_kill           (resp_kill),
    .resp_forward        (resp_forward),
    .resp_sleep          (resp_sleep),
    .resp_stq_index      (resp_stq_index),
    .resp_data           (resp_data),
    .wakeup_valid        (wakeup_valid),
    .wakeup_ldq_index    (wakeup_ldq_index),
    .wakeup_ready        (wakeup_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: sleep table and the outputs expected after the next edge
  bit          m_sleep   [LQ];
  int          m_wait    [LQ];
  bit          m_partial [LQ];
  logic        e_rv, e_kill, e_fwd, e_slp, e_wv;
  int          e_ri, e_si, e_wi;
  logic [31:0] e_data;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < LQ; j++) begin
      m_sleep[j] = 0; m_wait[j] = 0; m_partial[j] = 0;
    end
    e_rv = 0; e_kill = 0; e_fwd = 0; e_slp = 0; e_wv = 0;
    e_ri = 0; e_si = 0; e_wi = 0; e_data = '0;
  endtask

  // Evaluate the rules on the inputs currently applied, i.e. for the coming edge
  task automatic predict();
    load_queue_entry ld;
    int  best, sel, age;
    bit  ov, found, full, fwd, slp, hold;
    ld   = ldq[search_ldq_index];
    best = -1; sel = 0;
    for (int i = 0; i < SQ; i++) begin
      age = (i - int'(stq_head) + SQ) % SQ;
      ov  = ld.store_mask[i] && stq[i].valid && stq[i].address_valid
         && ((stq[i].address >> 2) == (ld.address >> 2))
         && ((stq[i].byte_mask & ld.byte_mask) != 0);
      if (ov && age > best) begin best = age; sel = i; end
    end
    found = (best >= 0);
    full  = found && ((stq[sel].byte_mask & ld.byte_mask) == ld.byte_mask);
    fwd   = search_valid && found && full && stq[sel].data_valid;
    slp   = search_valid && found && !fwd;
    hold  = e_wv && !wakeup_ready;
    if (flush) begin
      model_reset();
      return;
    end
    if (e_wv && wakeup_ready) m_sleep[e_wi] = 0;
    if (search_valid) begin
      m_sleep[search_ldq_index] = slp;
      if (slp) begin m_wait[search_ldq_index] = sel; m_partial[search_ldq_index] = !full; end
    end
    if (ldq_dealloc_valid) m_sleep[ldq_dealloc_index] = 0;
    e_rv   = search_valid;
    e_ri   = search_valid ? int'(search_ldq_index) : 0;
    e_kill = search_valid && found;
    e_fwd  = fwd;
    e_slp  = slp;
    e_si   = fwd ? sel : 0;
    e_data = fwd ? stq[sel].data : '0;
    if (!hold) begin
      e_wv = 0; e_wi = 0;
      for (int j = 0; j < LQ; j++) begin
        if (m_sleep[j] && (!stq[m_wait[j]].valid || (!m_partial[j] && stq[m_wait[j]].data_valid))) begin
          e_wv = 1; e_wi = j;
          break;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    check("resp_valid",       resp_valid,       e_rv);
    check("resp_ldq_index",   resp_ldq_index,   e_ri);
    check("resp_kill",        resp_kill,        e_kill);
    check("resp_forward",     resp_forward,     e_fwd);
    check("resp_sleep",       resp_sleep,       e_slp);
    check("resp_stq_index",   resp_stq_index,   e_si);
    check("resp_data",        resp_data,        e_data);
    check("wakeup_valid",     wakeup_valid,     e_wv);
    check("wakeup_ldq_index", wakeup_ldq_index, e_wi);
  endtask

  task automatic step();
    predict();
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic idle_inputs();
    search_valid = 0; search_ldq_index = 0; flush = 0;
    ldq_dealloc_valid = 0; ldq_dealloc_index = 0; wakeup_ready = 0; stq_head = 0;
  endtask

  task automatic clear_queues();
    for (int j = 0; j < LQ; j++) ldq[j] = '0;
    for (int i = 0; i < SQ; i++) stq[i] = '0;
  endtask

  function automatic store_queue_entry mk_st(logic [31:0] a, logic [3:0] m, logic dv, logic [31:0] d);
    store_queue_entry s;
    s = '{valid: 1'b1, address_valid: 1'b1, address: a, byte_mask: m, data_valid: dv, data: d};
    return s;
  endfunction

  task automatic search(input int idx);
    search_valid = 1; search_ldq_index = 3'(idx);
    step();
    search_valid = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    clear_queues();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_outputs();
    reset = 0;

    // Youngest of two full-cover stores across wrap-around (head=6)
    ldq[0] = '{address: 32'h100, byte_mask: 4'hF, store_mask: 8'b0100_0010};
    stq[6] = mk_st(32'h100, 4'hF, 1'b1, 32'hAAAA_6666);
    stq[1] = mk_st(32'h100, 4'hF, 1'b1, 32'hBBBB_1111);
    stq_head = 3'd6;
    search(0);
    check("wrap_kill",   resp_kill,      1);
    check("wrap_fwd",    resp_forward,   1);
    check("wrap_stqidx", resp_stq_index, 1);
    check("wrap_data",   resp_data,      32'hBBBB_1111);
    step();
    check("wrap_single_resp", resp_valid, 0);

    // Partial cover: sleeps until the covering store leaves the queue
    clear_queues(); stq_head = 0;
    ldq[3] = '{address: 32'h200, byte_mask: 4'hF, store_mask: 8'b0001_0100};
    stq[2] = mk_st(32'h200, 4'hF, 1'b1, 32'h2222_2222);
    stq[4] = mk_st(32'h202, 4'b0011, 1'b0, 32'h4444_4444);
    search(3);
    check("partial_kill",  resp_kill,    1);
    check("partial_sleep", resp_sleep,   1);
    check("partial_fwd",   resp_forward, 0);
    stq[4].data_valid = 1;
    step(); step();
    check("partial_ignores_data", wakeup_valid, 0);
    stq[4].valid = 0;
    step();
    check("partial_wake",     wakeup_valid,     1);
    check("partial_wake_idx", wakeup_ldq_index, 3);
    wakeup_ready = 1;
    step();
    check("partial_ack", wakeup_valid, 0);
    wakeup_ready = 0;

    // Full cover without data: wake on data_valid, held until accepted
    clear_queues();
    ldq[1] = '{address: 32'h300, byte_mask: 4'b0011, store_mask: 8'b0010_0000};
    stq[5] = mk_st(32'h300, 4'hF, 1'b0, 32'h5555_5555);
    search(1);
    check("pending_sleep", resp_sleep, 1);
    step(); step();
    check("pending_no_early_wake", wakeup_valid, 0);
    stq[5].data_valid = 1;
    step();
    check("pending_wake",     wakeup_valid,     1);
    check("pending_wake_idx", wakeup_ldq_index, 1);
    step(); step();
    check("pending_hold",     wakeup_valid,     1);
    check("pending_hold_idx", wakeup_ldq_index, 1);
    wakeup_ready = 1;
    step();
    check("pending_cleared", wakeup_valid, 0);
    wakeup_ready = 0;

    // Two loads become wakeable together: lower index first
    clear_queues();
    ldq[2] = '{address: 32'h400, byte_mask: 4'hF, store_mask: 8'b0000_1000};
    ldq[5] = '{address: 32'h500, byte_mask: 4'hF, store_mask: 8'b0100_0000};
    stq[3] = mk_st(32'h400, 4'hF, 1'b0, 32'h3333_3333);
    stq[6] = mk_st(32'h500, 4'hF, 1'b0, 32'h6666_6666);
    search(2);
    search(5);
    stq[3].data_valid = 1; stq[6].data_valid = 1;
    step();
    check("prio_first", wakeup_ldq_index, 2);
    wakeup_ready = 1;
    step();
    check("prio_second_vld", wakeup_valid,     1);
    check("prio_second",     wakeup_ldq_index, 5);
    step();
    check("prio_drained", wakeup_valid, 0);
    wakeup_ready = 0;

    // Flush the cycle after a search with sleeps pending
    clear_queues();
    ldq[0] = '{address: 32'h600, byte_mask: 4'hF, store_mask: 8'b0000_0001};
    ldq[4] = ldq[0];
    ldq[6] = ldq[0];
    stq[0] = mk_st(32'h600, 4'hF, 1'b0, 32'h6060_6060);
    search(0);
    search(4);
    search_valid = 1; search_ldq_index = 3'd6; flush = 1;
    step();
    search_valid = 0; flush = 0;
    check("flush_resp", resp_valid,   0);
    check("flush_wake", wakeup_valid, 0);
    stq[0].valid = 0;
    step(); step();
    check("flush_no_wake",    wakeup_valid, 0);
    check("flush_sleep_bits", dut.sleeping, 0);

    // Asynchronous reset while a response is on the outputs
    clear_queues();
    ldq[7] = '{address: 32'h700, byte_mask: 4'hF, store_mask: 8'b1000_0000};
    stq[7] = mk_st(32'h700, 4'hF, 1'b1, 32'h7777_7777);
    search(7);
    check("pre_reset_resp", resp_valid, 1);
    #3 reset = 1;
    #1;
    check("rst_resp_valid", resp_valid,   0);
    check("rst_fwd",        resp_forward, 0);
    check("rst_kill",       resp_kill,    0);
    check("rst_data",       resp_data,    0);
    check("rst_stq_index",  resp_stq_index, 0);
    check("rst_wake",       wakeup_valid, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 0;

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < SQ; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          stq[i].valid         = ($urandom_range(0, 3) != 0);
          stq[i].address_valid = ($urandom_range(0, 7) != 0);
          stq[i].address       = 32'h100 + 32'($urandom_range(0, 1) * 4) + 32'($urandom_range(0, 3));
          stq[i].byte_mask     = 4'($urandom_range(1, 15));
          stq[i].data_valid    = ($urandom_range(0, 2) == 0);
          stq[i].data          = $urandom;
        end
      end
      begin
        int k;
        k = $urandom_range(0, LQ - 1);
        ldq[k].address    = 32'h100 + 32'($urandom_range(0, 1) * 4);
        ldq[k].byte_mask  = 4'($urandom_range(1, 15));
        ldq[k].store_mask = 8'($urandom);
      end
      if ($urandom_range(0, 7) == 0) stq_head = 3'($urandom);
      search_valid      = ($urandom_range(0, 9) < 6);
      search_ldq_index  = 3'($urandom);
      ldq_dealloc_valid = ($urandom_range(0, 9) == 0);
      ldq_dealloc_index = 3'($urandom);
      flush             = ($urandom_range(0, 49) == 0);
      wakeup_ready      = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_forward_unit.md
LOAD_STORE_FORWARD_UNIT -- requirements
Module: load_store_forward_unit

Interface
REQ-001 SHALL take parameters LDQ_SIZE (default 8): load queue depth; STQ_SIZE (default 8): store queue depth; XLEN (default 32): data and address width.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 load_queue_entries  in  LDQ_SIZE x load_queue_entry  load queue state: address, byte_mask, store_mask.
REQ-005 store_queue_entries  in  STQ_SIZE x store_queue_entry  store queue state: valid, address_valid, address, byte_mask, data_valid, data (lane-aligned).
REQ-006 stq_head  in  clog2(STQ_SIZE)  index of the oldest store.
REQ-007 search_valid, search_ldq_index  in  1, clog2(LDQ_SIZE)  search request for one load.
REQ-008 flush  in  1  pipeline flush; clears all state.
REQ-009 ldq_dealloc_valid, ldq_dealloc_index  in  1, clog2(LDQ_SIZE)  load entry freed.
REQ-010 resp_valid, resp_ldq_index  out  1, clog2(LDQ_SIZE)  registered search result.
REQ-011 resp_kill, resp_forward, resp_sleep  out  1 each  kill the L1 request / data forwarded / load put to sleep.
REQ-012 resp_stq_index, resp_data  out  clog2(STQ_SIZE), XLEN  forwarding store index and its lane-aligned data.
REQ-013 wakeup_valid, wakeup_ldq_index  out  1, clog2(LDQ_SIZE)  sleeping load ready to replay; wakeup_ready  in  1  consumer accepts.

Function
REQ-014 Overlap for store i SHALL be: store_mask[i] of the searched load && valid && address_valid && address[XLEN-1:2] equal && (byte_mask & load byte_mask) != 0.
REQ-015 SHALL select the youngest overlapping store, measured as the largest (i - stq_head) mod STQ_SIZE, including across queue wrap-around.
REQ-016 Full cover SHALL mean (selected store byte_mask & load byte_mask) == load byte_mask.
REQ-017 Outcomes: no overlap -> kill=0, forward=0, sleep=0; full cover && data_valid -> kill=1, forward=1, sleep=0; otherwise -> kill=1, forward=0, sleep=1.
REQ-018 Latency SHALL be exactly one cycle: a search in cycle N drives resp_* in cycle N+1. resp_valid SHALL be high for one cycle per request, with one request accepted per cycle.
REQ-019 resp_stq_index and resp_data SHALL be 0 unless resp_forward=1.
REQ-020 The sleep table SHALL hold, per LDQ entry: a sleeping bit, a wait_stq_index, and a reason (DATA_PENDING or PARTIAL).
REQ-021 A sleep outcome SHALL set the entry at the same edge that produces resp_*. Reason is DATA_PENDING when the store fully covers the load, otherwise PARTIAL.
REQ-022 Wake condition SHALL be level-evaluated on registered state: sleeping && (!stq[wait].valid || (reason==DATA_PENDING && stq[wait].data_valid)).
REQ-023 wakeup_valid SHALL assert for the lowest-index entry whose wake condition holds. On wakeup_valid && wakeup_ready, that entry's sleeping bit SHALL clear. Without ready, the output SHALL hold stable.
REQ-024 A search of an already-sleeping load SHALL overwrite its sleep entry with the new outcome. A no-sleep outcome SHALL clear it.
REQ-025 ldq_dealloc SHALL clear the entry's sleeping bit. A dealloc coinciding with a sleep set on the same index SHALL win.
REQ-026 flush SHALL clear all sleeping bits, deassert resp_valid in the next cycle, and suppress wakeup_valid in the next cycle. flush takes priority over every other event.

Reset
REQ-027 Reset SHALL clear all sleeping bits and wait indices, and drive every output to 0 (resp_* and wakeup_*) until the first post-reset event.
REQ-028 A reset asserted mid-operation SHALL discard any pending response and all sleep state immediately, without waiting for a clock edge.

Structure
REQ-029 load_queue_entry, store_queue_entry (with byte_mask), LDQ_SIZE, STQ_SIZE and the sleep-reason enum SHALL live in lsu_pkg.
REQ-030 The youngest-store selection SHALL reuse sub-module youngest_entry_select (QUEUE_SIZE=STQ_SIZE). Wakeup arbitration SHALL be a fixed-priority encoder inside this module.

Verification
REQ-031 Test: stq_head=6; stores 6 and 1 both full-cover the load at 0x100 with data_valid. Required: resp next cycle with kill=1, forward=1, stq_index=1, and data from store 1.
REQ-032 Test: load byte_mask 4'b1111; youngest overlapping store byte_mask 4'b0011. Required: kill=1, sleep=1, reason PARTIAL. When that store's valid drops -> wakeup_valid with that LDQ index.
REQ-033 Test: full cover with data_valid=0. Required: sleep with reason DATA_PENDING. When data_valid rises -> wakeup_valid next cycle, held until wakeup_ready, then cleared.
REQ-034 Test: loads 2 and 5 wake in the same cycle. Required: index 2 first, index 5 in the cycle after ready.
REQ-035 Test: flush in the cycle after a search while sleeps are pending. Required: resp_valid=0, no wakeup issued, all sleeping bits 0.
REQ-036 Test: reset asserted between clock edges while resp_valid=1. Required: all outputs 0 immediately.
